dmem_access_ctrl: RTL and testbench

- Sequences the MEM stage against a variable-latency data memory using a req/ack handshake.
- While an access is outstanding it freezes the upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM).
- It also forces a bubble into the MEM/WB register so no write-back happens until the load data is valid.
- It sits between the EX/MEM register outputs and the MEM/WB register inputs, and feeds the hazard unit.

---
 rtl/dmem_access_ctrl_pkg.sv | 12 +
 rtl/dmem_timeout_cnt.sv | 28 ++
 rtl/dmem_access_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared FSM encoding and defaults for the data-memory access controller
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// rtl/dmem_timeout_cnt.sv - wait-cycle counter with clear, increment enable and expiry flag
module dmem_timeout_cnt #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Flags the increment that brings the count up to LIMIT, so the owner can act in that same cycle.
    assign expired = inc && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage req/ack sequencer with pipeline stall, WB bubble and timeout
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memreadm,
    input  logic        memwritem,
    input  logic        flushm,
    input  logic [31:0] addrm,
    input  logic [31:0] wdatam,
    input  logic [3:0]  bem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic        memwb_bubble,
    output logic [31:0] readdatam,
    output logic        mem_fault,
    output logic [31:0] stall_cnt
);

    dmem_state_t state;
    logic        access;
    logic        cnt_expired;

    assign access = (memreadm | memwritem) & ~flushm;

    // Nothing is frozen while reset is held, even if a memory op still sits in EX/MEM.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = access & rst_n;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign memwb_bubble = stall_o;

    dmem_timeout_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != BUSY),
        .inc     (state == BUSY),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            readdatam  <= '0;
            mem_fault  <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwritem;
                        dmem_addr  <= addrm;
                        dmem_wdata <= wdatam;
                        dmem_be    <= bem;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving on the expiry cycle still completes the access cleanly.
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            readdatam <= dmem_rdata;
                        end
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (cnt_expired) begin
                        dmem_req  <= 1'b0;
                        readdatam <= '0;
                        mem_fault <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    dmem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memreadm, memwritem, flushm;
    logic [31:0] addrm, wdatam;
    logic [3:0]  bem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_o, memwb_bubble;
    logic [31:0] readdatam;
    logic        mem_fault;
    logic [31:0] stall_cnt;

    logic        to_rd, ack_to;
    logic        t_req, t_we, t_stall, t_bubble, t_fault;
    logic [31:0] t_addr, t_wdata, t_rdata, t_cnt;
    logic [3:0]  t_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl u_dut (
        .clk (clk), .rst_n (rst_n),
        .memreadm (memreadm), .memwritem (memwritem), .flushm (flushm),
        .addrm (addrm), .wdatam (wdatam), .bem (bem),
        .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
        .dmem_wdata (dmem_wdata), .dmem_be (dmem_be),
        .dmem_ack (dmem_ack), .dmem_rdata (dmem_rdata),
        .stall_o (stall_o), .memwb_bubble (memwb_bubble), .readdatam (readdatam),
        .mem_fault (mem_fault), .stall_cnt (stall_cnt)
    );

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_to (
        .clk (clk), .rst_n (rst_n),
        .memreadm (to_rd), .memwritem (1'b0), .flushm (1'b0),
        .addrm (addrm), .wdatam (wdatam), .bem (bem),
        .dmem_req (t_req), .dmem_we (t_we), .dmem_addr (t_addr),
        .dmem_wdata (t_wdata), .dmem_be (t_be),
        .dmem_ack (ack_to), .dmem_rdata (dmem_rdata),
        .stall_o (t_stall), .memwb_bubble (t_bubble), .readdatam (t_rdata),
        .mem_fault (t_fault), .stall_cnt (t_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one access: cycle 0 is IDLE-detect, ack on cycle delay+1, DONE on delay+2.
    task automatic run_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] b, input logic [31:0] rd, input int delay,
                              input int flush_at, output int stalls, output int reqs,
                              output int bad, output logic [31:0] done_rd);
        stalls = 0; reqs = 0; bad = 0; done_rd = '0;
        for (int c = 0; c <= delay + 2; c++) begin
            memreadm   = !we && (c <= delay + 1);
            memwritem  = we && (c <= delay + 1);
            addrm      = (c == 0) ? a : ~a;
            wdatam     = (c == 0) ? wd : ~wd;
            bem        = (c == 0) ? b : ~b;
            flushm     = (flush_at >= 0) && (c >= flush_at) && (c <= delay + 1);
            dmem_ack   = (c == delay + 1);
            dmem_rdata = (c == delay + 1) ? rd : 32'h0BAD_F00D;
            @(negedge clk);
            if (stall_o) stalls++;
            if (dmem_req) begin
                reqs++;
                if (dmem_addr !== a || dmem_wdata !== wd || dmem_be !== b || dmem_we !== we) bad++;
            end
            if (stall_o !== memwb_bubble) bad++;
            if (c == delay + 2) done_rd = readdatam;
            tick();
        end
        memreadm = 0; memwritem = 0; flushm = 0; dmem_ack = 0;
        addrm = '0; wdatam = '0; bem = '0; dmem_rdata = '0;
    endtask

    task automatic test_reset;
        rst_n = 0; memreadm = 0; memwritem = 0; flushm = 0;
        addrm = '0; wdatam = '0; bem = '0; dmem_ack = 0; dmem_rdata = '0;
        to_rd = 0; ack_to = 0;
        #3;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, readdatam, mem_fault, stall_cnt, stall_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h be=%h rd=%h flt=%b cnt=%0d stall=%b required all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, readdatam, mem_fault, stall_cnt, stall_o);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_load;
        int s, r, b;
        logic [31:0] d;
        run_access(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, -1, s, r, b, d);
        checks++; if (s !== 2) begin failures++; $display("FAIL load_stall_cycles: got %0d required 2", s); end
        checks++; if (r !== 1) begin failures++; $display("FAIL load_req_cycles: got %0d required 1", r); end
        checks++; if (b !== 0) begin failures++; $display("FAIL load_latch_stable: got %0d bad cycles required 0", b); end
        checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_readdata: got %h required deadbeef", d); end
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL load_stall_cnt: got %0d required 2", stall_cnt); end
        tick();
    endtask

    task automatic test_store;
        int s, r, b;
        logic [31:0] d;
        run_access(1'b1, 32'h200, 32'h1234, 4'b0011, 32'h7777_7777, 5, -1, s, r, b, d);
        checks++; if (s !== 7) begin failures++; $display("FAIL store_stall_cycles: got %0d required 7", s); end
        checks++; if (r !== 6) begin failures++; $display("FAIL store_req_cycles: got %0d required 6", r); end
        checks++; if (b !== 0) begin failures++; $display("FAIL store_latch_stable: got %0d bad cycles required 0", b); end
        checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_readdata_held: got %h required deadbeef", d); end
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd9) begin failures++; $display("FAIL store_stall_cnt: got %0d required 9", stall_cnt); end
        tick();
    endtask

    task automatic test_back_to_back;
        int s1, r1, b1, s2, r2, b2;
        logic [31:0] d1, d2;
        run_access(1'b0, 32'h10, 32'h0, 4'hF, 32'hAAAA_0010, 0, -1, s1, r1, b1, d1);
        run_access(1'b0, 32'h14, 32'h0, 4'hF, 32'hBBBB_0014, 0, -1, s2, r2, b2, d2);
        checks++; if (d1 !== 32'hAAAA_0010 || d2 !== 32'hBBBB_0014) begin
            failures++; $display("FAIL b2b_data_order: got %h,%h required aaaa0010,bbbb0014", d1, d2);
        end
        checks++; if (r1 !== 1 || r2 !== 1 || s1 + s2 !== 4 || b1 + b2 !== 0) begin
            failures++; $display("FAIL b2b_phases: got req=%0d,%0d stall=%0d bad=%0d required req=1,1 stall=4 bad=0", r1, r2, s1 + s2, b1 + b2);
        end
    endtask

    task automatic test_flush;
        int s, r, b;
        logic [31:0] d;
        memreadm = 1; flushm = 1; addrm = 32'h300;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || memwb_bubble !== 1'b0) begin
            failures++; $display("FAIL flush_idle_stall: got stall=%b bubble=%b required 0,0", stall_o, memwb_bubble);
        end
        tick();
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL flush_idle_req: got %b required 0", dmem_req); end
        memreadm = 0; flushm = 0;
        tick();
        run_access(1'b0, 32'h304, 32'h0, 4'hF, 32'hC0DE_0304, 2, 1, s, r, b, d);
        checks++; if (r !== 3 || s !== 4 || d !== 32'hC0DE_0304) begin
            failures++; $display("FAIL flush_busy_completes: got req=%0d stall=%0d rd=%h required 3,4,c0de0304", r, s, d);
        end
    endtask

    task automatic test_timeout;
        int reqs, faults, fault_at, stalls;
        to_rd = 1; tick();
        ack_to = 1; dmem_rdata = 32'hCAFE_0001; tick();
        to_rd = 0; ack_to = 0; dmem_rdata = '0;
        @(negedge clk);
        checks++; if (t_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL timeout_preload: got %h required cafe0001", t_rdata); end
        tick();
        reqs = 0; faults = 0; fault_at = -1;
        for (int c = 0; c <= 6; c++) begin
            to_rd = (c <= 4);
            @(negedge clk);
            if (t_req) reqs++;
            if (t_fault) begin faults++; fault_at = c; end
            if (c == 5) begin
                checks++; if (t_rdata !== 32'h0 || t_stall !== 1'b0) begin
                    failures++; $display("FAIL timeout_done: got rd=%h stall=%b required 0,0", t_rdata, t_stall);
                end
            end
            tick();
        end
        checks++; if (reqs !== 4) begin failures++; $display("FAIL timeout_req_cycles: got %0d required 4", reqs); end
        checks++; if (faults !== 1 || fault_at !== 5) begin
            failures++; $display("FAIL timeout_fault_pulse: got %0d pulses at %0d required 1 at 5", faults, fault_at);
        end
        faults = 0; stalls = 0;
        for (int c = 0; c <= 5; c++) begin
            to_rd = (c <= 4);
            ack_to = (c == 4);
            dmem_rdata = (c == 4) ? 32'h5A5A_5A5A : 32'h0;
            @(negedge clk);
            if (t_fault) faults++;
            if (t_stall) stalls++;
            tick();
        end
        to_rd = 0; ack_to = 0; dmem_rdata = '0;
        @(negedge clk);
        checks++; if (faults !== 0 || stalls !== 5 || t_rdata !== 32'h5A5A_5A5A) begin
            failures++; $display("FAIL timeout_ack_wins: got faults=%0d stalls=%0d rd=%h required 0,5,5a5a5a5a", faults, stalls, t_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access;
        int s, r, b;
        logic [31:0] d;
        memreadm = 1; addrm = 32'h400; tick();
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1 || stall_o !== 1'b1) begin
            failures++; $display("FAIL rst_pre_busy: got req=%b stall=%b required 1,1", dmem_req, stall_o);
        end
        #1 rst_n = 0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_o !== 1'b0 || memwb_bubble !== 1'b0) begin
            failures++; $display("FAIL rst_async_drop: got req=%b stall=%b bubble=%b required 0,0,0", dmem_req, stall_o, memwb_bubble);
        end
        memreadm = 0; addrm = '0;
        #1 rst_n = 1;
        tick();
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd0 || dmem_req !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL rst_release: got cnt=%0d req=%b stall=%b required 0,0,0", stall_cnt, dmem_req, stall_o);
        end
        tick();
        run_access(1'b0, 32'h500, 32'h0, 4'hF, 32'h1357_9BDF, 1, -1, s, r, b, d);
        checks++; if (s !== 3 || r !== 2 || d !== 32'h1357_9BDF) begin
            failures++; $display("FAIL rst_then_load: got stall=%0d req=%0d rd=%h required 3,2,13579bdf", s, r, d);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
